handshake_fifo_buffer: RTL
==========================

HANDSHAKE_FIFO_BUFFER -- requirements
Module: handshake_fifo_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the data token.
REQ-002 Parameter NUM_SLOTS, default 4, storage depth in tokens; legal range 2..64, need not be a power of two.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ins  input  DATA_WIDTH  upstream data token, for example the output of a constant stage.
REQ-006 ins_valid  input  1  upstream token present.
REQ-007 ins_ready  output  1  buffer accepts a token this cycle.
REQ-008 outs  output  DATA_WIDTH  head token.
REQ-009 outs_valid  output  1  head token present.
REQ-010 outs_ready  input  1  downstream accepts the head token.

Function
REQ-011 The block SHALL be a non-transparent elastic FIFO; a token pushed at edge N SHALL appear on outs with outs_valid=1 no earlier than the cycle after edge N, giving a minimum latency of 1 cycle.
REQ-012 A push SHALL occur at a rising edge iff ins_valid && ins_ready, and a pop iff outs_valid && outs_ready.
REQ-013 ins_ready SHALL equal (count != NUM_SLOTS), decoded from registered state only with no combinational path from outs_ready.
REQ-014 outs_valid SHALL equal (count != 0) and outs SHALL equal storage[rd_ptr], both registered-state-only with no combinational path from ins or ins_valid.
REQ-015 count SHALL have width clog2(NUM_SLOTS+1), incrementing on push-only, decrementing on pop-only, and holding on push+pop or on neither.
REQ-016 wr_ptr and rd_ptr SHALL have width clog2(NUM_SLOTS), advance by 1 on push and pop respectively, and wrap from NUM_SLOTS-1 to 0.
REQ-017 Full boundary: ins_ready=0, so no push occurs even if a pop happens in the same cycle; a slot freed by a pop SHALL be writable from the next cycle.
REQ-018 Empty boundary: outs_valid=0 and no pop occurs; a simultaneous push SHALL become visible in the next cycle, with no bypass.
REQ-019 Simultaneous push and pop at 0 < count < NUM_SLOTS: both pointers advance and count is unchanged.
REQ-020 Token order SHALL be strictly FIFO, and no token SHALL be duplicated or dropped.
REQ-021 While outs_valid=1 and outs_ready=0, outs SHALL remain stable.

Reset
REQ-022 Asserting rst low SHALL immediately clear count, wr_ptr, rd_ptr and all storage to 0, forcing outs_valid=0, ins_ready=1 and outs=0.
REQ-023 Reset asserted mid-operation SHALL discard all buffered tokens, with no partial push or pop completing.
REQ-024 Normal operation SHALL resume at the first rising edge after rst deasserts.

Structure
REQ-025 A shared package SHALL hold the localparams PTR_W = clog2(NUM_SLOTS) and CNT_W = clog2(NUM_SLOTS+1), together with the clog2 function.
REQ-026 A sub-module handshake_fifo_ptr (wrapping modulo-NUM_SLOTS counter with enable) SHALL be instantiated twice, once for wr_ptr and once for rd_ptr.
REQ-027 Storage SHALL be a register array with no RAM macro.

Verification
REQ-028 Reset, then no stimulus -> outs_valid=0, ins_ready=1, outs=0.
REQ-029 NUM_SLOTS=4, outs_ready=0, push 0xFFFFFFFF, 1, 2, 3 -> ins_ready=0 after the 4th push, and a 5th token held on ins is not accepted.
REQ-030 Continuing from the full state, assert outs_ready=1 and hold ins_valid=1 with ins=4 -> outs sequence 0xFFFFFFFF, 1, 2, 3, 4 in order, with 4 accepted only after the first pop.
REQ-031 Empty buffer, single push of 0x5 -> outs_valid=1 exactly one cycle later with outs=0x5.
REQ-032 NUM_SLOTS=3, continuous push and pop over 10 tokens -> correct order through pointer wrap, and count stays at 1 in steady state.
REQ-033 Fill with 2 tokens, then assert rst low between clock edges -> outs_valid=0 at once, and after release the next push is the first token output.

Source files
------------

// File: rtl/handshake_fifo_buffer_pkg.sv
// Shared sizing helpers for the handshake FIFO buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package handshake_fifo_buffer_pkg;

  // Ceiling log2; returns the bit count needed to index n distinct values.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Widths for the default configuration. Instances that override NUM_SLOTS
  // derive their own widths from clog2 using the same formulas.
  localparam int DEF_NUM_SLOTS = 4;
  localparam int PTR_W         = clog2(DEF_NUM_SLOTS);
  localparam int CNT_W         = clog2(DEF_NUM_SLOTS + 1);

endpackage

// File: rtl/handshake_fifo_ptr.sv
// Wrapping modulo-NUM_SLOTS pointer with advance enable.
// Latency: new value visible the cycle after en_i is sampled high.
// Backpressure: none; the caller gates en_i with its handshake.
module handshake_fifo_ptr
  import handshake_fifo_buffer_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int W         = clog2(NUM_SLOTS)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer: advance by one, wrapping from the last slot back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == W'(NUM_SLOTS - 1)) ? '0 : ptr_q + W'(1);
    end
  end

  // Pointer register, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/handshake_fifo_buffer.sv
// Non-transparent elastic FIFO of NUM_SLOTS register slots with valid/ready on both sides.
// Latency: 1 cycle minimum from push edge to outs_valid; no empty bypass.
// Backpressure: ins_ready drops at full (even if popping); outs holds steady while outs_ready is low.
module handshake_fifo_buffer
  import handshake_fifo_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  // Widths for this instance's depth (package values cover the default depth).
  localparam int PW = clog2(NUM_SLOTS);
  localparam int CW = clog2(NUM_SLOTS + 1);

  logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  // Both handshake outputs come from registered count only, so neither side's
  // inputs reach the other side's outputs combinationally.
  assign ins_ready  = (count_q != CW'(NUM_SLOTS));
  assign outs_valid = (count_q != '0);
  assign outs       = mem_q[rd_ptr];

  assign push = ins_valid && ins_ready;
  assign pop  = outs_valid && outs_ready;

  handshake_fifo_ptr #(
    .NUM_SLOTS (NUM_SLOTS),
    .W         (PW)
  ) u_wr_ptr (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (push),
    .ptr_o  (wr_ptr)
  );

  handshake_fifo_ptr #(
    .NUM_SLOTS (NUM_SLOTS),
    .W         (PW)
  ) u_rd_ptr (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (pop),
    .ptr_o  (rd_ptr)
  );

  // Occupancy: up on push-only, down on pop-only, hold otherwise.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Occupancy register; reset discards everything buffered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Slot storage: write the accepted token at wr_ptr; reset zeroes all slots so outs reads 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr] <= ins;
    end
  end

endmodule
